// File: rtl/video_pkg.sv
// Shared video table definitions: parameter codes, per-table entry limits and
// the write scheduler state type.
package video_pkg;

  localparam logic [1:0] PARAM_PALDEF  = 2'd0;
  localparam logic [1:0] PARAM_TILEDEF = 2'd1;
  localparam logic [1:0] PARAM_PALMAP  = 2'd2;
  localparam logic [1:0] PARAM_TILEMAP = 2'd3;

  localparam logic [10:0] LIMIT_PALDEF  = 11'd16;
  localparam logic [10:0] LIMIT_TILEDEF = 11'd256;
  localparam logic [10:0] LIMIT_PALMAP  = 11'd1200;
  localparam logic [10:0] LIMIT_TILEMAP = 11'd1200;

  typedef enum logic {StIdle, StFill} sched_state_e;

  function automatic logic [10:0] table_limit(input logic [1:0] param);
    logic [10:0] lim;
    case (param)
      PARAM_PALDEF:  lim = LIMIT_PALDEF;
      PARAM_TILEDEF: lim = LIMIT_TILEDEF;
      PARAM_PALMAP:  lim = LIMIT_PALMAP;
      default:       lim = LIMIT_TILEMAP;
    endcase
    return lim;
  endfunction

  function automatic logic [10:0] clamp_count(input logic [1:0] param, input logic [10:0] count);
    logic [10:0] lim;
    lim = table_limit(param);
    return (count > lim) ? lim : count;
  endfunction

endpackage

// File: rtl/video_write_sched.sv
// Arbitrates CPU single writes against block fills onto one registered video
// write port; CPU has priority, with a starvation guard for pending fills.
module video_write_sched
  import video_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_req,
  input  logic [1:0]  cpu_param,
  input  logic [10:0] cpu_index,
  input  logic [15:0] cpu_val,
  output logic        cpu_ready,
  input  logic        fill_start,
  input  logic [1:0]  fill_param,
  input  logic [10:0] fill_base,
  input  logic [10:0] fill_count,
  input  logic [15:0] fill_val,
  output logic        fill_busy,
  output logic        fill_done,
  output logic        wen,
  output logic [1:0]  w_param,
  output logic [10:0] w_index,
  output logic [15:0] w_val
);

  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

  sched_state_e state_q, state_d;
  logic [10:0]  idx_q, idx_d;
  logic [10:0]  remain_q, remain_d;
  logic [1:0]   fparam_q, fparam_d;
  logic [15:0]  fval_q, fval_d;
  logic [StarveW-1:0] starve_q, starve_d;
  logic         done_q, done_d;
  logic         wen_q, wen_d;
  logic [1:0]   w_param_q, w_param_d;
  logic [10:0]  w_index_q, w_index_d;
  logic [15:0]  w_val_q, w_val_d;

  logic         cpu_grant, fill_grant;
  logic [10:0]  start_count, fill_limit;

  always_comb begin
    cpu_ready   = !(state_q == StFill && starve_q == StarveW'(STARVE_LIMIT));
    cpu_grant   = cpu_req && cpu_ready;
    fill_grant  = (state_q == StFill) && !cpu_grant;
    start_count = clamp_count(fill_param, fill_count);
    fill_limit  = table_limit(fparam_q);

    state_d   = state_q;
    idx_d     = idx_q;
    remain_d  = remain_q;
    fparam_d  = fparam_q;
    fval_d    = fval_q;
    starve_d  = starve_q;
    done_d    = 1'b0;
    wen_d     = 1'b0;
    w_param_d = w_param_q;
    w_index_d = w_index_q;
    w_val_d   = w_val_q;

    if (cpu_grant) begin
      wen_d     = 1'b1;
      w_param_d = cpu_param;
      w_index_d = cpu_index;
      w_val_d   = cpu_val;
    end else if (fill_grant) begin
      wen_d     = 1'b1;
      w_param_d = fparam_q;
      w_index_d = idx_q;
      w_val_d   = fval_q;
    end

    unique case (state_q)
      StIdle: begin
        starve_d = '0;
        if (fill_start) begin
          if (start_count == 11'd0) begin
            done_d = 1'b1;
          end else begin
            state_d  = StFill;
            idx_d    = fill_base;
            remain_d = start_count;
            fparam_d = fill_param;
            fval_d   = fill_val;
          end
        end
      end
      StFill: begin
        if (fill_grant) begin
          starve_d = '0;
          // Out-of-range bases also fold back to 0 once they pass the limit.
          idx_d    = (idx_q >= fill_limit - 11'd1) ? 11'd0 : idx_q + 11'd1;
          remain_d = remain_q - 11'd1;
          if (remain_q == 11'd1) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end else if (cpu_grant) begin
          starve_d = starve_q + StarveW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      remain_q  <= '0;
      fparam_q  <= '0;
      fval_q    <= '0;
      starve_q  <= '0;
      done_q    <= 1'b0;
      wen_q     <= 1'b0;
      w_param_q <= '0;
      w_index_q <= '0;
      w_val_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      remain_q  <= remain_d;
      fparam_q  <= fparam_d;
      fval_q    <= fval_d;
      starve_q  <= starve_d;
      done_q    <= done_d;
      wen_q     <= wen_d;
      w_param_q <= w_param_d;
      w_index_q <= w_index_d;
      w_val_q   <= w_val_d;
    end
  end

  assign fill_busy = (state_q == StFill);
  assign fill_done = done_q;
  assign wen       = wen_q;
  assign w_param   = w_param_q;
  assign w_index   = w_index_q;
  assign w_val     = w_val_q;

endmodule

// File: tb/tb_video_write_sched.sv
// Bench for video_write_sched: CPU vector table plus hand sequences for fills,
// starvation, clamping, busy restart and reset abort, checked via a write queue.
module tb_video_write_sched;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cpu_req;
  logic [1:0]  cpu_param;
  logic [10:0] cpu_index;
  logic [15:0] cpu_val;
  logic        cpu_ready;
  logic        fill_start;
  logic [1:0]  fill_param;
  logic [10:0] fill_base;
  logic [10:0] fill_count;
  logic [15:0] fill_val;
  logic        fill_busy;
  logic        fill_done;
  logic        wen;
  logic [1:0]  w_param;
  logic [10:0] w_index;
  logic [15:0] w_val;

  always #5 clk = ~clk;

  video_write_sched #(.STARVE_LIMIT(8)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .cpu_req    (cpu_req),
    .cpu_param  (cpu_param),
    .cpu_index  (cpu_index),
    .cpu_val    (cpu_val),
    .cpu_ready  (cpu_ready),
    .fill_start (fill_start),
    .fill_param (fill_param),
    .fill_base  (fill_base),
    .fill_count (fill_count),
    .fill_val   (fill_val),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .wen        (wen),
    .w_param    (w_param),
    .w_index    (w_index),
    .w_val      (w_val)
  );

  typedef struct {
    logic [1:0]  param;
    logic [10:0] index;
    logic [15:0] val;
    logic        last;
  } wr_t;

  typedef struct {
    logic        req;
    logic [1:0]  param;
    logic [10:0] index;
    logic [15:0] val;
  } cpu_vec_t;

  wr_t      exp_q[$];
  wr_t      mon_e;
  cpu_vec_t vecs[6];
  int       checks = 0;
  int       errors = 0;
  int       done_seen = 0;
  bit       mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] p, input logic [10:0] i, input logic [15:0] v,
                      input logic last);
    wr_t e;
    e.param = p; e.index = i; e.val = v; e.last = last;
    exp_q.push_back(e);
  endtask

  // Independent model of a fill: clamp to table size, wrap index at the limit.
  task automatic push_fill(input logic [1:0] p, input int base, input int count,
                           input logic [15:0] v);
    int lim, n, idx;
    case (p)
      2'd0: lim = 16;
      2'd1: lim = 256;
      default: lim = 1200;
    endcase
    n   = (count > lim) ? lim : count;
    idx = base;
    for (int k = 0; k < n; k++) begin
      push(p, idx[10:0], v, k == n - 1);
      idx = (idx + 1 == lim) ? 0 : idx + 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_fill(input logic [1:0] p, input logic [10:0] b, input logic [10:0] c,
                            input logic [15:0] v);
    fill_start = 1'b1; fill_param = p; fill_base = b; fill_count = c; fill_val = v;
    tick();
    fill_start = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int i = 0;
    while ((exp_q.size() != 0 || fill_busy) && i < budget) begin
      tick();
      i++;
    end
    chk({name, "_drained"}, {31'd0, exp_q.size() == 0 && !fill_busy}, 32'd1);
    repeat (3) tick();
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (fill_done) done_seen++;
      if (wen) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_wen", {21'd0, w_index}, 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          chk("w_param", {30'd0, w_param}, {30'd0, mon_e.param});
          chk("w_index", {21'd0, w_index}, {21'd0, mon_e.index});
          chk("w_val", {16'd0, w_val}, {16'd0, mon_e.val});
          chk("done_with_write", {31'd0, fill_done}, {31'd0, mon_e.last});
        end
      end
    end
  end

  initial begin
    int done_ref;
    logic prev_req;
    logic [15:0] last_val;

    vecs[0] = '{1'b1, 2'd0, 11'd5,    16'h00F0};
    vecs[1] = '{1'b1, 2'd1, 11'd255,  16'hBEEF};
    vecs[2] = '{1'b0, 2'd2, 11'd9,    16'h1111};
    vecs[3] = '{1'b1, 2'd2, 11'd1500, 16'h1234};
    vecs[4] = '{1'b0, 2'd3, 11'd3,    16'h2222};
    vecs[5] = '{1'b1, 2'd3, 11'h7FF,  16'hA5A5};

    resetn = 1'b0; cpu_req = 1'b0; cpu_param = '0; cpu_index = '0; cpu_val = '0;
    fill_start = 1'b0; fill_param = '0; fill_base = '0; fill_count = '0; fill_val = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wen", {31'd0, wen}, 32'd0);
    chk("rst_w_index", {21'd0, w_index}, 32'd0);
    chk("rst_w_val", {16'd0, w_val}, 32'd0);
    chk("rst_busy", {31'd0, fill_busy}, 32'd0);
    chk("rst_done", {31'd0, fill_done}, 32'd0);
    chk("rst_ready", {31'd0, cpu_ready}, 32'd1);
    resetn = 1'b1;
    mon_en = 1'b1;
    tick();

    // CPU write table: one-cycle latency, index passed through unchecked.
    prev_req = 1'b0;
    last_val = '0;
    for (int i = 0; i < 6; i++) begin
      cpu_req = vecs[i].req; cpu_param = vecs[i].param;
      cpu_index = vecs[i].index; cpu_val = vecs[i].val;
      if (vecs[i].req) begin
        push(vecs[i].param, vecs[i].index, vecs[i].val, 1'b0);
        last_val = vecs[i].val;
      end
      @(negedge clk);
      chk("cpu_ready_idle", {31'd0, cpu_ready}, 32'd1);
      chk("cpu_latency", {31'd0, wen}, {31'd0, prev_req});
      prev_req = vecs[i].req;
      tick();
    end
    cpu_req = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    chk("hold_wen", {31'd0, wen}, 32'd0);
    chk("hold_w_index", {21'd0, w_index}, 32'h7FF);
    chk("hold_w_val", {16'd0, w_val}, {16'd0, last_val});
    tick();

    // Fill with wrap; first wen two cycles after fill_start.
    done_ref = done_seen;
    push_fill(2'd2, 1198, 4, 16'h0021);
    start_fill(2'd2, 11'd1198, 11'd4, 16'h0021);
    @(negedge clk);
    chk("fill_first_gap", {31'd0, wen}, 32'd0);
    chk("fill_busy_on", {31'd0, fill_busy}, 32'd1);
    wait_drain("wrap", 20);
    chk("wrap_done_count", done_seen - done_ref, 32'd1);

    // Starvation: CPU requests every cycle from the cycle after fill_start.
    done_ref = done_seen;
    start_fill(2'd1, 11'd20, 11'd3, 16'h003C);
    for (int k = 1; k <= 27; k++) begin
      cpu_req = 1'b1; cpu_param = 2'd3;
      cpu_index = 11'(500 + k); cpu_val = 16'(16'h1000 + k);
      if (k % 9 == 0) push(2'd1, 11'(20 + k / 9 - 1), 16'h003C, k == 27);
      else push(2'd3, 11'(500 + k), 16'(16'h1000 + k), 1'b0);
      @(negedge clk);
      chk("starve_ready", {31'd0, cpu_ready}, {31'd0, (k % 9) != 0});
      tick();
    end
    cpu_req = 1'b0;
    wait_drain("starve", 20);
    chk("starve_done_count", done_seen - done_ref, 32'd1);

    // Clamp: paldef count 40 gives 16 writes.
    done_ref = done_seen;
    push_fill(2'd0, 3, 40, 16'h0055);
    start_fill(2'd0, 11'd3, 11'd40, 16'h0055);
    wait_drain("clamp", 40);
    chk("clamp_done_count", done_seen - done_ref, 32'd1);

    // Zero count: no writes, done in the next cycle, never busy.
    done_ref = done_seen;
    fill_start = 1'b1; fill_param = 2'd1; fill_base = 11'd7; fill_count = 11'd0;
    @(negedge clk);
    chk("zero_done_early", {31'd0, fill_done}, 32'd0);
    tick();
    fill_start = 1'b0;
    @(negedge clk);
    chk("zero_done", {31'd0, fill_done}, 32'd1);
    chk("zero_busy", {31'd0, fill_busy}, 32'd0);
    chk("zero_wen", {31'd0, wen}, 32'd0);
    repeat (3) tick();
    chk("zero_done_count", done_seen - done_ref, 32'd1);

    // Busy restart is ignored.
    done_ref = done_seen;
    push_fill(2'd1, 10, 5, 16'h00AA);
    start_fill(2'd1, 11'd10, 11'd5, 16'h00AA);
    tick();
    start_fill(2'd3, 11'd0, 11'd3, 16'h00BB);
    wait_drain("restart", 20);
    chk("restart_done_count", done_seen - done_ref, 32'd1);

    // Reset after the 2nd of 10 writes aborts the fill.
    done_ref = done_seen;
    push(2'd3, 11'd100, 16'h0077, 1'b0);
    push(2'd3, 11'd101, 16'h0077, 1'b0);
    start_fill(2'd3, 11'd100, 11'd10, 16'h0077);
    repeat (3) @(negedge clk);
    #1 resetn = 1'b0;
    #1;
    chk("abort_queue", exp_q.size(), 32'd0);
    chk("abort_wen", {31'd0, wen}, 32'd0);
    chk("abort_w_index", {21'd0, w_index}, 32'd0);
    chk("abort_w_val", {16'd0, w_val}, 32'd0);
    chk("abort_busy", {31'd0, fill_busy}, 32'd0);
    chk("abort_ready", {31'd0, cpu_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #3 resetn = 1'b1;
    repeat (15) tick();
    chk("abort_done_count", done_seen - done_ref, 32'd0);
    chk("abort_idle", {31'd0, fill_busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/video_write_sched.md
VIDEO_WRITE_SCHED -- requirements
Module: video_write_sched

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8: maximum consecutive CPU grants while a fill is pending.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port cpu_req  input  1  CPU single-write request, valid for one cycle.
REQ-005 SHALL have port cpu_param  input  2  target table: 0 paldef, 1 tiledef, 2 palmap, 3 tilemap.
REQ-006 SHALL have port cpu_index  input  11  CPU target index.
REQ-007 SHALL have port cpu_val  input  16  CPU write value.
REQ-008 SHALL have port cpu_ready  output  1  CPU write accepted when cpu_req and cpu_ready are both high.
REQ-009 SHALL have port fill_start  input  1  one-cycle strobe that starts a block fill.
REQ-010 SHALL have ports fill_param (input, 2), fill_base (input, 11), fill_count (input, 11) and fill_val (input, 16): the fill descriptor, sampled on fill_start.
REQ-011 SHALL have port fill_busy  output  1  fill in progress.
REQ-012 SHALL have port fill_done  output  1  one-cycle pulse on fill completion.
REQ-013 SHALL have ports wen (output, 1), w_param (output, 2), w_index (output, 11) and w_val (output, 16): the registered write port to the video block.

Function
REQ-014 SHALL implement an FSM with states IDLE and FILL.
REQ-015 SHALL move IDLE->FILL on fill_start with a nonzero clamped count, and FILL->IDLE after the last fill write is issued.
REQ-016 SHALL clamp the table limit per param: paldef 16, tiledef 256, palmap 1200, tilemap 1200; count = min(fill_count, limit).
REQ-017 SHALL, on fill_start with clamped count 0, issue no writes, stay in IDLE and pulse fill_done in the next cycle.
REQ-018 SHALL ignore fill_start while fill_busy is high.
REQ-019 SHALL increment the fill index by 1 per fill write and wrap it to 0 at the table limit.
REQ-020 SHALL grant at most one write per cycle; CPU priority: when a CPU write is accepted, fill does not advance that cycle.
REQ-021 SHALL drive cpu_ready low for exactly one cycle, granting fill, when in FILL and the consecutive-CPU-grant counter equals STARVE_LIMIT; the counter then clears.
REQ-022 SHALL clear the starvation counter on every fill grant and whenever the state is IDLE.
REQ-023 SHALL drive cpu_ready high at all other times, including IDLE.
REQ-024 SHALL register granted writes and present them on w_* with wen=1 in the cycle after the grant, at one-cycle latency.
REQ-025 SHALL hold wen at 0 in cycles with no grant; w_param, w_index and w_val hold their last values.
REQ-026 SHALL deassert fill_busy and pulse fill_done in the same cycle the last fill write appears on wen.
REQ-027 SHALL grant fill on the fill_start edge when cpu_req is low at that edge; the first fill wen follows 2 cycles after fill_start.
REQ-028 SHALL pass cpu_index through unmodified, with no range checking on CPU writes.

Reset
REQ-029 SHALL, on resetn low, asynchronously force state IDLE, counters 0, wen=0, w_param=0, w_index=0, w_val=0, fill_busy=0, fill_done=0 and cpu_ready=1.
REQ-030 SHALL abort a fill interrupted by reset with no fill_done pulse and no further writes after reset release.

Structure
REQ-031 SHALL take the param codes (PARAM_PALDEF..PARAM_TILEMAP), the table limits (16/256/1200/1200) and the FSM state type from a shared package video_pkg, which the video block also uses.
REQ-032 SHALL be a single module with no sub-modules; the index/count logic is too small to split out.

Verification
REQ-033 SHALL verify a CPU write: cpu_req=1, param=0, index=5, val=0x0F0 -> next cycle wen=1, w_param=0, w_index=5, w_val=0x0F0; cpu_ready stays 1.
REQ-034 SHALL verify a fill with wrap: fill_start, param=2, base=1198, count=4, val=0x21, no CPU traffic -> wen for 4 cycles with indices 1198, 1199, 0, 1, then fill_done pulse alongside the last write.
REQ-035 SHALL verify starvation: fill of count 3 with cpu_req held high continuously -> 8 CPU writes, cpu_ready low for one cycle with one fill write, pattern repeats until fill_done.
REQ-036 SHALL verify clamping and zero count: param=0, count=40 -> exactly 16 writes; count=0 -> no wen and fill_done next cycle.
REQ-037 SHALL verify a busy-time restart: fill_start asserted while fill_busy=1 with a different descriptor -> ignored; the original fill completes unchanged.
REQ-038 SHALL verify reset mid-fill: resetn low after the 2nd of 10 writes -> all outputs at reset values immediately, no fill_done, and no wen after release.
